// File: rtl/adc_sample_scheduler.sv
// Sample-rate scheduler for an LTC2308-style ADC engine: times frames, scans the
// channel mask round-robin, issues config words and forwards tagged results.
module adc_sample_scheduler #(
  parameter int DIV_W    = 16,
  parameter bit UNIPOLAR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] sample_div,
  input  logic [7:0]       ch_mask,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [5:0]       cmd_cfg,
  input  logic             rsp_valid,
  input  logic [11:0]      rsp_data,
  output logic             smp_valid,
  input  logic             smp_ready,
  output logic [11:0]      smp_data,
  output logic [2:0]       smp_ch,
  output logic             smp_frame_start,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RSP, S_OUTPUT} state_t;

  state_t           state;
  logic [DIV_W-1:0] count;
  logic [7:0]       frame_mask;
  logic [2:0]       cur_ch;
  logic             first;

  logic [DIV_W-1:0] period_m1;
  logic             tick;
  logic [7:0]       above;
  logic [2:0]       next_ch;
  logic [2:0]       start_ch;

  // NOTE: the result is given a value before the loop so every path assigns it;
  // the same rule keeps combinational logic from inferring latches.
  function automatic logic [2:0] lowest_ch(input logic [7:0] m);
    lowest_ch = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_ch = 3'(i);
    end
  endfunction

  // {S/D, O/S, S1, S0, UNI, SLP}: single-ended, odd channel on O/S, awake.
  function automatic logic [5:0] cfg_word(input logic [2:0] ch);
    return {1'b1, ch[0], ch[2], ch[1], UNIPOLAR, 1'b0};
  endfunction

  // Periods below 2 would leave no room for the wrap; clamp to 2.
  assign period_m1 = (sample_div < DIV_W'(2)) ? DIV_W'(1) : sample_div - DIV_W'(1);
  assign tick      = enable && (count == period_m1);
  assign above     = frame_mask & (8'hFE << cur_ch);
  assign next_ch   = lowest_ch(above);
  assign start_ch  = lowest_ch(ch_mask);

  // NOTE: every register in this block uses non-blocking assignment so all
  // next-state values are computed from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      count           <= '0;
      frame_mask      <= '0;
      cur_ch          <= '0;
      first           <= 1'b0;
      cmd_valid       <= 1'b0;
      cmd_cfg         <= '0;
      smp_valid       <= 1'b0;
      smp_data        <= '0;
      smp_ch          <= '0;
      smp_frame_start <= 1'b0;
      overrun         <= 1'b0;
      busy            <= 1'b0;
    end else begin
      if (!enable || tick) count <= '0;
      else                 count <= count + 1'b1;

      // A tick that cannot start a frame is dropped and flagged; set beats clear.
      if (tick && state != S_IDLE) overrun <= 1'b1;
      else if (overrun_clr)        overrun <= 1'b0;

      case (state)
        S_IDLE: begin
          if (tick && ch_mask != 8'h00) begin
            frame_mask <= ch_mask;
            cur_ch     <= start_ch;
            first      <= 1'b1;
            cmd_cfg    <= cfg_word(start_ch);
            cmd_valid  <= 1'b1;
            busy       <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (rsp_valid) begin
            smp_data        <= rsp_data;
            smp_ch          <= cur_ch;
            smp_frame_start <= first;
            smp_valid       <= 1'b1;
            state           <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (smp_ready) begin
            smp_valid       <= 1'b0;
            smp_frame_start <= 1'b0;
            if (above != 8'h00) begin
              cur_ch    <= next_ch;
              first     <= 1'b0;
              cmd_cfg   <= cfg_word(next_ch);
              cmd_valid <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed bench for adc_sample_scheduler: table of frames plus hand-written
// sequences for overrun, degenerate configuration and mid-frame reset.
module tb_adc_sample_scheduler;

  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [DIV_W-1:0] sample_div;
  logic [7:0]       ch_mask;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [5:0]       cmd_cfg;
  logic             rsp_valid;
  logic [11:0]      rsp_data;
  logic             smp_valid;
  logic             smp_ready;
  logic [11:0]      smp_data;
  logic [2:0]       smp_ch;
  logic             smp_frame_start;
  logic             overrun;
  logic             overrun_clr;
  logic             busy;

  adc_sample_scheduler #(.DIV_W(DIV_W), .UNIPOLAR(1'b1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_div(sample_div),
    .ch_mask(ch_mask), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_cfg(cmd_cfg), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_data(smp_data),
    .smp_ch(smp_ch), .smp_frame_start(smp_frame_start), .overrun(overrun),
    .overrun_clr(overrun_clr), .busy(busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0]  mask;
    int          lat;
    int          bp_ch;
    int          bp_n;
    logic [11:0] base;
    int          exp_n;
  } frame_vec_t;

  frame_vec_t  tab [7];
  logic [5:0]  cfg_tab [8];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_cmd(input int limit);
    int n = 0;
    while (!cmd_valid && n < limit) begin
      step();
      n++;
    end
  endtask

  // One conversion, starting with cmd_valid visible and cmd_ready/smp_ready high.
  task automatic do_sample(input logic [2:0] ch, input logic fs, input logic last,
                           input int lat, input logic [11:0] data, input int bp);
    check("cmd_valid", cmd_valid, 1);
    check("cmd_cfg", cmd_cfg, cfg_tab[ch]);
    check("busy_issue", busy, 1);
    step();
    check("cmd_drop", cmd_valid, 0);
    repeat (lat - 1) step();
    rsp_valid = 1'b1;
    rsp_data  = data;
    step();
    rsp_valid = 1'b0;
    check("smp_valid", smp_valid, 1);
    check("smp_data", smp_data, data);
    check("smp_ch", smp_ch, ch);
    check("smp_frame_start", smp_frame_start, fs);
    if (bp > 0) begin
      smp_ready = 1'b0;
      repeat (bp) begin
        step();
        check("bp_valid", smp_valid, 1);
        check("bp_data", smp_data, data);
        check("bp_ch", smp_ch, ch);
        check("bp_no_cmd", cmd_valid, 0);
      end
      smp_ready = 1'b1;
    end
    step();
    check("smp_hs_drop", smp_valid, 0);
    if (last) begin
      check("busy_end", busy, 0);
      check("no_cmd_end", cmd_valid, 0);
    end else begin
      check("next_cmd", cmd_valid, 1);
    end
  endtask

  task automatic run_frame(input logic [7:0] mask, input int lat, input int bp_ch,
                           input int bp_n, input logic [11:0] base,
                           output int t_start, output int n_smp);
    logic first = 1'b1;
    n_smp = 0;
    wait_cmd(400);
    t_start = cyc;
    check("frame_cmd_seen", cmd_valid, 1);
    if (!cmd_valid) return;
    for (int c = 0; c < 8; c++) begin
      if (mask[c]) begin
        do_sample(3'(c), first, (mask >> (c + 1)) == 0, lat, base + 12'(c),
                  (c == bp_ch) ? bp_n : 0);
        // Disturb the live mask mid-frame; the latched frame must not notice.
        if (first) ch_mask = mask ^ 8'h0F;
        first = 1'b0;
        n_smp++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t, t_prev, n, r, e, t0, t2;
    logic saw;

    cfg_tab = '{6'b100010, 6'b110010, 6'b100110, 6'b110110,
                6'b101010, 6'b111010, 6'b101110, 6'b111110};
    tab[0] = '{8'h01, 3, 8, 0,  12'hABC, 1};
    tab[1] = '{8'h01, 3, 8, 0,  12'h123, 1};
    tab[2] = '{8'hA5, 3, 8, 0,  12'h200, 4};
    tab[3] = '{8'hA5, 3, 2, 10, 12'h300, 4};
    tab[4] = '{8'h80, 1, 8, 0,  12'h400, 1};
    tab[5] = '{8'h5A, 2, 6, 3,  12'h500, 4};
    tab[6] = '{8'hFF, 1, 7, 2,  12'h600, 8};

    rst = 1'b1; enable = 1'b0; sample_div = '0; ch_mask = '0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    smp_ready = 1'b0; overrun_clr = 1'b0;
    repeat (3) step();
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_cfg", cmd_cfg, 0);
    check("rst_smp_valid", smp_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);

    // Table of frames at sample_div=100: one frame per tick, period exact.
    sample_div = 100; cmd_ready = 1'b1; smp_ready = 1'b1; enable = 1'b1;
    r = cyc;
    rst = 1'b0;
    t_prev = r;
    for (int i = 0; i < 7; i++) begin
      ch_mask = tab[i].mask;
      run_frame(tab[i].mask, tab[i].lat, tab[i].bp_ch, tab[i].bp_n, tab[i].base, t, n);
      check("frame_len", n, tab[i].exp_n);
      check("frame_period", t - t_prev, 100);
      check("frame_overrun", overrun, 0);
      t_prev = t;
    end

    // Empty mask: ticks ignored, no overrun.
    ch_mask = 8'h00;
    saw = 1'b0;
    repeat (250) begin
      step();
      saw |= cmd_valid;
    end
    check("mask0_no_cmd", saw, 0);
    check("mask0_overrun", overrun, 0);

    // Spurious response while idle.
    rsp_valid = 1'b1; rsp_data = 12'h5A5;
    step();
    rsp_valid = 1'b0;
    check("spurious_smp", smp_valid, 0);
    check("spurious_busy", busy, 0);

    // enable=0 holds the timer at 0.
    enable = 1'b0;
    step();
    ch_mask = 8'h01; sample_div = 5;
    saw = 1'b0;
    repeat (40) begin
      step();
      saw |= cmd_valid;
    end
    check("disabled_no_cmd", saw, 0);
    enable = 1'b1;
    e = cyc;
    wait_cmd(20);
    check("enable_first_tick", cyc - e, 5);

    // sample_div of 0 and 1 behave as 2.
    rst = 1'b1; step(); rst = 1'b0; sample_div = 0;
    r = cyc;
    wait_cmd(10);
    check("div0_first_tick", cyc - r, 2);
    rst = 1'b1; step(); rst = 1'b0; sample_div = 1;
    r = cyc;
    wait_cmd(10);
    check("div1_first_tick", cyc - r, 2);

    // Overrun: 8 channels x 12 cycles never fit in a 20-cycle period.
    rst = 1'b1; sample_div = 20; ch_mask = 8'hFF;
    step();
    rst = 1'b0;
    r = cyc;
    check("ovr_after_rst", overrun, 0);
    wait_cmd(100);
    t0 = cyc;
    check("ovr_first_tick", t0 - r, 20);
    run_frame(8'hFF, 10, 8, 0, 12'h700, t, n);
    check("ovr_set", overrun, 1);
    ch_mask = 8'hFF;
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("ovr_clr", overrun, 0);
    cmd_ready = 1'b0;
    wait_cmd(100);
    t2 = cyc;
    check("ovr_next_frame", t2 - t0, 100);
    while (cyc < t2 + 19) step();
    check("ovr_stall_clear", overrun, 0);
    check("ovr_stall_cmd", cmd_valid, 1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("ovr_set_wins", overrun, 1);
    cmd_ready = 1'b1;
    run_frame(8'hFF, 10, 8, 0, 12'h800, t, n);
    check("ovr_frame2_len", n, 8);
    check("ovr_sticky", overrun, 1);

    // Reset while waiting for a response.
    sample_div = 50; ch_mask = 8'h01;
    wait_cmd(100);
    step();
    check("wr_cmd_low", cmd_valid, 0);
    check("wr_busy", busy, 1);
    step();
    check("pre_rst_overrun", overrun, 1);
    rst = 1'b1;
    step();
    r = cyc;
    rst = 1'b0;
    rsp_valid = 1'b1; rsp_data = 12'hFFF;
    check("mid_rst_cmd_valid", cmd_valid, 0);
    check("mid_rst_cmd_cfg", cmd_cfg, 0);
    check("mid_rst_smp_valid", smp_valid, 0);
    check("mid_rst_smp_data", smp_data, 0);
    check("mid_rst_smp_ch", smp_ch, 0);
    check("mid_rst_fs", smp_frame_start, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_busy", busy, 0);
    step();
    rsp_valid = 1'b0;
    check("post_rst_rsp_ignored", smp_valid, 0);
    check("post_rst_idle", busy, 0);
    wait_cmd(200);
    check("post_rst_first_tick", cyc - r, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
